mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU memory bus, in front of the top-level address decoder/read-data mux.
- Master 0 is the picorv32 CPU. Master 1 is a DMA/loader engine that moves data into application RAM without CPU copies.
- All ports use the valid/ready/addr/wdata/wstrb handshake; the slave side drives the existing decoder unchanged.

Parameters:
- TIMEOUT_CYCLES, 255: cycles a granted access may wait for s_ready before the arbiter completes it locally (8-bit counter, 1..255).
- M1_PREFIX, 2'h1: only address area prefix (addr[31:30]) master 1 may access; default is RAM.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_valid  in  1  CPU request
- m0_instr  in  1  CPU instruction fetch flag
- m0_addr  in  32  CPU address
- m0_wdata  in  32  CPU write data
- m0_wstrb  in  4  CPU byte strobes; 0 = read
- m0_ready  out  1  CPU completion pulse
- m0_rdata  out  32  CPU read data
- m1_valid  in  1  DMA request
- m1_addr  in  32  DMA address
- m1_wdata  in  32  DMA write data
- m1_wstrb  in  4  DMA byte strobes
- m1_ready  out  1  DMA completion pulse
- m1_rdata  out  32  DMA read data
- m1_err  out  1  one-cycle pulse: DMA access refused or timed out
- s_valid  out  1  request to decoder
- s_instr  out  1  forwarded instr flag (0 for master 1)
- s_addr  out  32  forwarded address
- s_wdata  out  32  forwarded write data
- s_wstrb  out  4  forwarded strobes
- s_ready  in  1  decoder completion
- s_rdata  in  32  decoder read data
- grant  out  2  debug: 00 none, 01 m0, 10 m1

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, grant=00, last_grant=m1 (so the CPU wins the first tie), timeout count=0. All outputs are 0 while reset is asserted, including mid-transaction; s_valid drops immediately.
- States: IDLE, ARB, BUSY, DONE.
- IDLE: if any m*_valid, go to ARB next cycle. Requests are sampled each cycle.
- ARB: one cycle; registers the grant.
  - Only one master valid: grant it.
  - Both valid: round-robin; grant the master not in last_grant.
  - m1 granted with m1_addr[31:30] != M1_PREFIX: no forwarding. Go to DONE with m1_ready=1, m1_rdata=0, m1_err=1 for one cycle.
  - Otherwise go to BUSY.
- BUSY:
  - s_* = granted master's signals (combinational mux); s_instr=0 for m1.
  - On s_ready: route s_rdata and a one-cycle ready to the granted master; the other master's ready/rdata stay 0. Update last_grant and go to DONE.
  - Granted master drops valid before s_ready (protocol abort): go to IDLE with no response and deassert s_valid.
- DONE: one cycle with s_valid=0, so the master can deassert valid. Then IDLE.
- Latency: 1 arbitration cycle plus decoder latency plus 1 DONE cycle. Back-to-back accesses by one master are at least 4 cycles apart.
- Fairness: under continuous requests from both masters, grants strictly alternate; neither waits more than one foreign transaction.
- m*_rdata is 0 whenever m*_ready is 0.

Optional Feature:
- Macro: MEM_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - In BUSY, an 8-bit counter increments each cycle without s_ready; it clears on entry to BUSY.
  - At count == TIMEOUT_CYCLES-1 with no s_ready, the arbiter drops s_valid and returns ready=1, rdata=0 to the granted master. It pulses m1_err if the master is m1, then goes to DONE.
  - An s_ready arriving in the same cycle as expiry wins: a normal response with no error.
- Not defined: no counter is instantiated; BUSY waits indefinitely for s_ready.

Decomposition:
- Shared package/include holds:
  - state encodings for IDLE, ARB, BUSY, DONE
  - grant encodings 00/01/10
  - area prefix constants (ROM 2'h0, RAM 2'h1, RESERVED 2'h2, MMIO 2'h3), reused by the decoder
  - ILLEGAL/zero read-data constant
- One natural sub-module, mem_bus_arb_timeout: counter plus expiry compare. It is instantiated only under MEM_BUS_ARBITER_TIMEOUT_EN.

Test Plan:
- CPU-only read:
  - Stimulus: m0_valid, addr 0x0000_0010, wstrb 0; decoder returns s_ready with rdata 0xDEAD_BEEF two cycles after s_valid.
  - Required: m0_ready pulses once with 0xDEAD_BEEF; grant=01 during BUSY; m1_ready stays 0.
- Simultaneous requests right after reset:
  - Stimulus: m0 and m1 both valid, both targeting 0x4000_0000.
  - Required: m0 served first, then m1; grants alternate 01,10,01,10 over four sustained requests from each.
- DMA prefix violation:
  - Stimulus: m1 write to 0xC000_0000 (MMIO).
  - Required: s_valid never asserts; m1_ready=1, m1_rdata=0, m1_err=1 for exactly one cycle.
- DMA write:
  - Stimulus: m1 write to 0x4000_0100, wdata 0x1234_5678, wstrb 4'hF.
  - Required: forwarded unchanged on s_*, s_instr=0; m1_ready pulses on s_ready.
- Reset mid-transaction:
  - Stimulus: assert reset in BUSY between clock edges.
  - Required: s_valid, grant and m*_ready go to 0 immediately without a clock edge; after release, the first tie goes to m0.
- Timeout (macro defined, TIMEOUT_CYCLES=8):
  - Stimulus: m1 read, s_ready held low.
  - Required: after 8 BUSY cycles, m1_ready=1, m1_rdata=0, m1_err=1.
  - Stimulus: repeat with s_ready arriving in the expiry cycle.
  - Required: normal data returned, no m1_err.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared definitions for the CPU memory bus arbiter and the address decoder:
// arbiter FSM states, debug grant encodings, address area prefixes
// (addr[31:30]) and the zero read-data value returned on refused or
// timed-out accesses.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_BUSY = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'b00,
      GRANT_M0   = 2'b01,
      GRANT_M1   = 2'b10
   } grant_e;

   localparam logic [1:0] AREA_ROM      = 2'h0;
   localparam logic [1:0] AREA_RAM      = 2'h1;
   localparam logic [1:0] AREA_RESERVED = 2'h2;
   localparam logic [1:0] AREA_MMIO     = 2'h3;

   localparam logic [31:0] RDATA_ZERO = '0;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
// valid/ready memory bus used on both master ports and the slave port.
//   valid  request, held by the initiator until ready
//   addr   byte address
//   wdata  write data
//   wstrb  byte strobes, 0 = read
//   ready  one-cycle completion pulse from the responder
//   rdata  read data, valid while ready is high
// Modports: master = initiator side, slave = responder side.
interface mem_bus_arbiter_if;

   logic        valid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready;
   logic [31:0] rdata;

   modport master (
      output valid, addr, wdata, wstrb,
      input  ready, rdata
   );

   modport slave (
      input  valid, addr, wdata, wstrb,
      output ready, rdata
   );

endinterface

// File: rtl/mem_bus_arb_timeout.sv
// mem_bus_arb_timeout
// Access watchdog for the arbiter BUSY state. Only present in builds with
// MEM_BUS_ARBITER_TIMEOUT_EN defined.
//   clk, reset  system clock, asynchronous active-high reset
//   busy        arbiter is in BUSY; the counter is held at 0 otherwise
//   s_ready     decoder completion
//   expired     last waiting cycle reached without s_ready
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
module mem_bus_arb_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic busy,
   input  logic s_ready,
   output logic expired
);

   localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (!busy) begin
         count <= '0;
      end else if (!s_ready) begin
         count <= count + 8'd1;
      end
   end

   // A completing s_ready in the final cycle takes priority over expiry.
   assign expired = busy && !s_ready && (count == LAST_COUNT);

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Two-master, one-slave arbiter in front of the address decoder.
// Master 0 is the CPU, master 1 the DMA/loader engine (restricted to the
// M1_PREFIX address area). Ties are resolved round-robin.
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   m0          CPU bus (slave modport), m0_instr its fetch flag
//   m1          DMA bus (slave modport)
//   m1_err      one-cycle pulse: DMA access refused or timed out
//   s           decoder bus (master modport), s_instr forwarded fetch flag
//   grant       debug: 00 none, 01 m0, 10 m1
// Optional: MEM_BUS_ARBITER_TIMEOUT_EN adds a BUSY watchdog of
// TIMEOUT_CYCLES cycles that completes a stuck access locally.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [1:0]  M1_PREFIX      = AREA_RAM
) (
   input  logic              clk,
   input  logic              reset,
   mem_bus_arbiter_if.slave  m0,
   input  logic              m0_instr,
   mem_bus_arbiter_if.slave  m1,
   output logic              m1_err,
   mem_bus_arbiter_if.master s,
   output logic              s_instr,
   output logic [1:0]        grant
);

   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..255");
   end

   state_e state_q, state_d;
   grant_e grant_q, grant_d;
   grant_e last_q, last_d;
   logic   refused_q, refused_d;
   logic   gnt_m1;
   logic   g_valid;
   logic   timeout_hit;

   assign gnt_m1  = (grant_q == GRANT_M1);
   assign g_valid = gnt_m1 ? m1.valid : m0.valid;
   assign grant   = grant_q;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
   logic busy;

   assign busy = (state_q == ST_BUSY);

   mem_bus_arb_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .busy   (busy),
      .s_ready(s.ready),
      .expired(timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         grant_q   <= GRANT_NONE;
         last_q    <= GRANT_M1;
         refused_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         refused_q <= refused_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      refused_d = 1'b0;
      s.valid   = 1'b0;
      s.addr    = '0;
      s.wdata   = '0;
      s.wstrb   = '0;
      s_instr   = 1'b0;
      m0.ready  = 1'b0;
      m0.rdata  = RDATA_ZERO;
      m1.ready  = 1'b0;
      m1.rdata  = RDATA_ZERO;
      m1_err    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (m0.valid || m1.valid) begin
               state_d = ST_ARB;
            end
         end

         ST_ARB: begin
            if (m0.valid && (!m1.valid || (last_q == GRANT_M1))) begin
               grant_d = GRANT_M0;
               state_d = ST_BUSY;
            end else if (m1.valid) begin
               grant_d = GRANT_M1;
               if (m1.addr[31:30] != M1_PREFIX) begin
                  // Refusals count as a DMA turn so a DMA engine stuck on a
                  // bad address cannot starve the CPU.
                  refused_d = 1'b1;
                  last_d    = GRANT_M1;
                  state_d   = ST_DONE;
               end else begin
                  state_d = ST_BUSY;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_BUSY: begin
            if (!g_valid) begin
               grant_d = GRANT_NONE;
               state_d = ST_IDLE;
            end else begin
               s.valid = !timeout_hit;
               s.addr  = gnt_m1 ? m1.addr  : m0.addr;
               s.wdata = gnt_m1 ? m1.wdata : m0.wdata;
               s.wstrb = gnt_m1 ? m1.wstrb : m0.wstrb;
               s_instr = !gnt_m1 && m0_instr;
               if (s.ready || timeout_hit) begin
                  if (gnt_m1) begin
                     m1.ready = 1'b1;
                     m1.rdata = s.ready ? s.rdata : RDATA_ZERO;
                     m1_err   = timeout_hit;
                  end else begin
                     m0.ready = 1'b1;
                     m0.rdata = s.ready ? s.rdata : RDATA_ZERO;
                  end
                  last_d  = grant_q;
                  state_d = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            if (refused_q) begin
               m1.ready = 1'b1;
               m1_err   = 1'b1;
            end
            grant_d = GRANT_NONE;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       m0_instr;
   logic       m1_err;
   logic       s_instr;
   logic [1:0] grant;

   mem_bus_arbiter_if m0_bus();
   mem_bus_arbiter_if m1_bus();
   mem_bus_arbiter_if s_bus();

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .TIMEOUT_CYCLES(8),
      .M1_PREFIX     (AREA_RAM)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .m0      (m0_bus),
      .m0_instr(m0_instr),
      .m1      (m1_bus),
      .m1_err  (m1_err),
      .s       (s_bus),
      .s_instr (s_instr),
      .grant   (grant)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        instr;
      logic [1:0]  grant;
   } fwd_t;

   typedef struct {
      int unsigned master;
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   typedef struct {
      bit          m1;
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] dec_rdata;
      int unsigned lat;
      bit          exp_fwd;
      logic        exp_instr;
      logic [1:0]  exp_grant;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   fwd_t        fwd_q[$];
   resp_t       resp_q[$];
   logic [31:0] dec_q[$];

   int unsigned dec_lat    = 0;
   bit          dec_stall  = 1'b0;
   int unsigned dec_wait   = 0;
   int unsigned sv_cycles  = 0;

   task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) fail(name, act, exp);
   endtask

   task automatic expect_fwd(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input logic instr,
                             input logic [1:0] gnt, input logic [31:0] dec_rdata);
      fwd_t f;
      f.addr = addr; f.wdata = wdata; f.wstrb = wstrb; f.instr = instr; f.grant = gnt;
      fwd_q.push_back(f);
      dec_q.push_back(dec_rdata);
   endtask

   task automatic expect_resp(input int unsigned m, input logic [31:0] rdata, input logic err);
      resp_t r;
      r.master = m; r.rdata = rdata; r.err = err;
      resp_q.push_back(r);
   endtask

   task automatic check_resp(input int unsigned m, input logic [31:0] rdata, input logic err);
      resp_t e;
      if (resp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL resp_unexpected: master %0d responded with 0x%08h, expected no response", m, rdata);
      end else begin
         e = resp_q.pop_front();
         chk("resp_master", 32'(m), 32'(e.master));
         chk("resp_rdata", rdata, e.rdata);
         chk("resp_err", 32'(err), 32'(e.err));
      end
   endtask

   task automatic check_fwd();
      fwd_t e;
      if (fwd_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL fwd_unexpected: s access to 0x%08h, expected none", s_bus.addr);
      end else begin
         e = fwd_q.pop_front();
         chk("fwd_addr", s_bus.addr, e.addr);
         chk("fwd_wdata", s_bus.wdata, e.wdata);
         chk("fwd_wstrb", 32'(s_bus.wstrb), 32'(e.wstrb));
         chk("fwd_instr", 32'(s_instr), 32'(e.instr));
         chk("fwd_grant", 32'(grant), 32'(e.grant));
      end
   endtask

   // Decoder model: answers dec_lat cycles after s_valid rises.
   initial begin
      s_bus.ready = 1'b0;
      s_bus.rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         s_bus.ready = 1'b0;
         s_bus.rdata = '0;
         if (s_bus.valid && !dec_stall) begin
            if (dec_wait >= dec_lat) begin
               s_bus.ready = 1'b1;
               s_bus.rdata = (dec_q.size() > 0) ? dec_q.pop_front() : 32'h0;
               dec_wait    = 0;
            end else begin
               dec_wait++;
            end
         end else begin
            dec_wait = 0;
         end
      end
   end

   // Response/forwarding monitor.
   always @(negedge clk) begin
      if (!reset) begin
         if (s_bus.valid) sv_cycles++;
         if (!m0_bus.ready) chk("m0_rdata_idle", m0_bus.rdata, 32'h0);
         if (!m1_bus.ready) begin
            chk("m1_rdata_idle", m1_bus.rdata, 32'h0);
            chk("m1_err_alone", 32'(m1_err), 32'h0);
         end
         if (m0_bus.ready) check_resp(0, m0_bus.rdata, 1'b0);
         if (m1_bus.ready) check_resp(1, m1_bus.rdata, m1_err);
         if (s_bus.valid && s_bus.ready) check_fwd();
      end
   end

   task automatic xact(input int unsigned m, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
      int unsigned n;
      logic        rdy;
      if (m == 0) begin
         m0_bus.valid = 1'b1; m0_instr = instr; m0_bus.addr = addr;
         m0_bus.wdata = wdata; m0_bus.wstrb = wstrb;
      end else begin
         m1_bus.valid = 1'b1; m1_bus.addr = addr;
         m1_bus.wdata = wdata; m1_bus.wstrb = wstrb;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
         rdy = (m == 0) ? m0_bus.ready : m1_bus.ready;
      end while (!rdy && n < 64);
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL xact_wait: master %0d got no ready within %0d cycles, expected ready", m, n);
      end
      @(posedge clk);
      #1;
      if (m == 0) begin
         m0_bus.valid = 1'b0; m0_instr = 1'b0; m0_bus.addr = '0;
         m0_bus.wdata = '0; m0_bus.wstrb = '0;
      end else begin
         m1_bus.valid = 1'b0; m1_bus.addr = '0;
         m1_bus.wdata = '0; m1_bus.wstrb = '0;
      end
   endtask

   task automatic wait_s_valid(input string name);
      int unsigned n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!s_bus.valid && n < 20);
      chk(name, 32'(s_bus.valid), 32'h1);
   endtask

   task automatic run_vec(input vec_t v);
      int unsigned sv0;
      dec_lat = v.lat;
      if (v.exp_fwd) expect_fwd(v.addr, v.wdata, v.wstrb, v.exp_instr, v.exp_grant, v.dec_rdata);
      expect_resp(v.m1 ? 1 : 0, v.exp_rdata, v.exp_err);
      sv0 = sv_cycles;
      if (v.m1) begin
         m0_instr = v.instr;   // must not leak onto s_instr for DMA accesses
         xact(1, 1'b0, v.addr, v.wdata, v.wstrb);
         m0_instr = 1'b0;
      end else begin
         xact(0, v.instr, v.addr, v.wdata, v.wstrb);
      end
      repeat (2) @(negedge clk);
      chk("vec_resp_drained", 32'(resp_q.size()), 32'h0);
      chk("vec_fwd_drained", 32'(fwd_q.size()), 32'h0);
      if (!v.exp_fwd) chk("vec_no_s_valid", 32'(sv_cycles - sv0), 32'h0);
   endtask

   vec_t vecs[9];

   initial begin
      int unsigned sv0;

      vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 2, 1'b1, 1'b0, 2'b01, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_0200, 32'h0, 4'h0, 32'h0000_0013, 0, 1'b1, 1'b1, 2'b01, 32'h0000_0013, 1'b0};
      vecs[2] = '{1'b0, 1'b0, {AREA_MMIO, 30'h4}, 32'h0000_AA55, 4'h3, 32'h0000_0077, 1, 1'b1, 1'b0, 2'b01, 32'h0000_0077, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 32'h4000_0100, 32'h1234_5678, 4'hF, 32'h0, 1, 1'b1, 1'b0, 2'b10, 32'h0, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 32'h4000_0FFC, 32'h0, 4'h0, 32'hCAFE_F00D, 3, 1'b1, 1'b0, 2'b10, 32'hCAFE_F00D, 1'b0};
      vecs[5] = '{1'b1, 1'b0, {AREA_MMIO, 30'h0}, 32'h1111_1111, 4'hF, 32'h5555_5555, 0, 1'b0, 1'b0, 2'b10, 32'h0, 1'b1};
      vecs[6] = '{1'b1, 1'b0, {AREA_ROM, 30'h0}, 32'h0, 4'h0, 32'h5555_5555, 0, 1'b0, 1'b0, 2'b10, 32'h0, 1'b1};
      vecs[7] = '{1'b1, 1'b0, {AREA_RESERVED, 30'h0}, 32'h0, 4'h0, 32'h5555_5555, 0, 1'b0, 1'b0, 2'b10, 32'h0, 1'b1};
      vecs[8] = '{1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'h0000_0001, 0, 1'b1, 1'b0, 2'b01, 32'h0000_0001, 1'b0};

      reset        = 1'b1;
      m0_instr     = 1'b0;
      m0_bus.valid = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
      m1_bus.valid = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_s_valid", 32'(s_bus.valid), 32'h0);
      chk("rst_m0_ready", 32'(m0_bus.ready), 32'h0);
      chk("rst_m1_ready", 32'(m1_bus.ready), 32'h0);
      chk("rst_m1_err", 32'(m1_err), 32'h0);
      reset = 1'b0;

      // Sustained requests from both masters straight after reset.
      dec_lat = 1;
      for (int i = 0; i < 4; i++) begin
         expect_fwd(32'h4000_0000, 32'h0, 4'h0, 1'b0, 2'b01, 32'h1000_0000 + 32'(i));
         expect_resp(0, 32'h1000_0000 + 32'(i), 1'b0);
         expect_fwd(32'h4000_0000, 32'hA000_0000 + 32'(i), 4'hF, 1'b0, 2'b10, 32'h2000_0000 + 32'(i));
         expect_resp(1, 32'h2000_0000 + 32'(i), 1'b0);
      end
      fork
         begin
            for (int i = 0; i < 4; i++) xact(0, 1'b0, 32'h4000_0000, 32'h0, 4'h0);
         end
         begin
            for (int j = 0; j < 4; j++) xact(1, 1'b0, 32'h4000_0000, 32'hA000_0000 + 32'(j), 4'hF);
         end
      join
      repeat (2) @(negedge clk);
      chk("rr_resp_drained", 32'(resp_q.size()), 32'h0);
      chk("rr_fwd_drained", 32'(fwd_q.size()), 32'h0);

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Reset in the middle of a CPU access.
      dec_stall    = 1'b1;
      m0_bus.valid = 1'b1; m0_bus.addr = 32'h4000_0040; m0_bus.wdata = '0; m0_bus.wstrb = '0;
      wait_s_valid("mid_busy_reached");
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_s_valid", 32'(s_bus.valid), 32'h0);
      chk("mid_rst_grant", 32'(grant), 32'h0);
      chk("mid_rst_m0_ready", 32'(m0_bus.ready), 32'h0);
      chk("mid_rst_m1_ready", 32'(m1_bus.ready), 32'h0);
      m0_bus.valid = 1'b0; m0_bus.addr = '0;
      repeat (2) @(posedge clk);
      #1;
      reset     = 1'b0;
      dec_stall = 1'b0;
      dec_lat   = 0;
      expect_fwd(32'h4000_0044, 32'h0, 4'h0, 1'b0, 2'b01, 32'h3333_0000);
      expect_resp(0, 32'h3333_0000, 1'b0);
      expect_fwd(32'h4000_0048, 32'h0, 4'h0, 1'b0, 2'b10, 32'h3333_0001);
      expect_resp(1, 32'h3333_0001, 1'b0);
      fork
         xact(0, 1'b0, 32'h4000_0044, 32'h0, 4'h0);
         xact(1, 1'b0, 32'h4000_0048, 32'h0, 4'h0);
      join
      repeat (2) @(negedge clk);
      chk("tie_resp_drained", 32'(resp_q.size()), 32'h0);

      // DMA drops valid while waiting on the decoder: no response expected.
      dec_stall    = 1'b1;
      m1_bus.valid = 1'b1; m1_bus.addr = 32'h4000_0080; m1_bus.wdata = '0; m1_bus.wstrb = '0;
      wait_s_valid("abort_busy_reached");
      m1_bus.valid = 1'b0;
      #1;
      chk("abort_s_valid", 32'(s_bus.valid), 32'h0);
      chk("abort_m1_ready", 32'(m1_bus.ready), 32'h0);
      repeat (3) @(negedge clk);
      chk("abort_grant_idle", 32'(grant), 32'h0);
      m1_bus.addr = '0;
      dec_stall   = 1'b0;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
      // Decoder never answers: local completion with error in BUSY cycle 8.
      dec_stall = 1'b1;
      expect_resp(1, 32'h0, 1'b1);
      sv0 = sv_cycles;
      xact(1, 1'b0, 32'h4000_0020, 32'h0, 4'h0);
      chk("to_s_valid_cycles", 32'(sv_cycles - sv0), 32'h7);
      repeat (2) @(negedge clk);
      chk("to_resp_drained", 32'(resp_q.size()), 32'h0);
      dec_stall = 1'b0;

      // Decoder answers in the expiry cycle: normal completion wins.
      dec_lat = 7;
      expect_fwd(32'h4000_0024, 32'h0, 4'h0, 1'b0, 2'b10, 32'h0BAD_CAFE);
      expect_resp(1, 32'h0BAD_CAFE, 1'b0);
      sv0 = sv_cycles;
      xact(1, 1'b0, 32'h4000_0024, 32'h0, 4'h0);
      chk("to_edge_s_valid_cycles", 32'(sv_cycles - sv0), 32'h8);
      repeat (2) @(negedge clk);
      chk("to_edge_resp_drained", 32'(resp_q.size()), 32'h0);
      chk("to_edge_fwd_drained", 32'(fwd_q.size()), 32'h0);
`else
      sv0 = sv_cycles;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
